// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
//   swState_e : controller state (IDLE, RUN, PAUSED, LAP)
//   btnEvt_t  : one-cycle button events after priority resolution
//   *_MAX     : terminal value of each BCD digit of the M:SS.t count
//   DP_MASK   : decimal-point pattern per scanned digit (bit = scan index)
package stopwatch_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        LAP    = 2'd3
    } swState_e;

    typedef struct packed {
        logic clear;
        logic lap;
        logic startStop;
    } btnEvt_t;

    localparam logic [DIGIT_W-1:0] TENTHS_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] SECU_MAX   = 4'd9;
    localparam logic [DIGIT_W-1:0] SECT_MAX   = 4'd5;
    localparam logic [DIGIT_W-1:0] MIN_MAX    = 4'd9;

    // dp lit under SS.t (index 1) and M: (index 3)
    localparam logic [NUM_DIGITS-1:0] DP_MASK = 4'b1010;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_counter.sv
// One BCD digit of the stopwatch cascade.
//   clk, reset : clock, async active-high reset
//   clr        : synchronous zero (takes priority over en)
//   en         : advance by one; wraps to 0 after max
//   max        : terminal value of this digit
//   q          : current digit value
//   carry      : digit is at max (next enable wraps it)
module bcd_digit_counter
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic [DIGIT_W-1:0] max,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    assign carry = (q == max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= carry ? '0 : q + DIGIT_W'(1);
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and sequencing core.
//   clk, reset         : clock, async active-high reset
//   btn_start_stop     : debounced async level, rising edge = event
//   btn_lap, btn_clear : debounced async levels, rising edge = event
//   count_bcd          : live count {min, sec_tens, sec_units, tenths}
//   digit_bcd/sel, dp  : time-multiplexed digit to the 7-seg decoder
//   running            : RUN or LAP
//   lap_active         : LAP (display frozen on snapshot)
//   min_ovf            : one-cycle pulse on the 9:59.9 -> 0:00.0 wrap
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 5_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [15:0] count_bcd,
    output logic [3:0]  digit_bcd,
    output logic [3:0]  digit_sel,
    output logic        dp,
    output logic        running,
    output logic        lap_active,
    output logic        min_ovf
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [NUM_DIGITS-1:0][DIGIT_W-1:0] DIG_MAX =
        {MIN_MAX, SECT_MAX, SECU_MAX, TENTHS_MAX};

    // ---------------- button sync + rising edge ----------------
    logic [2:0] btnRaw, syncMeta, syncLvl, syncPrev, btnRise;
    btnEvt_t    evt;

    assign btnRaw = {btn_clear, btn_lap, btn_start_stop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncMeta <= '0;
            syncLvl  <= '0;
            syncPrev <= '0;
        end else begin
            syncMeta <= btnRaw;
            syncLvl  <= syncMeta;
            syncPrev <= syncLvl;
        end
    end

    assign btnRise = syncLvl & ~syncPrev;

    // start_stop beats lap beats clear; losers are dropped, not queued
    always_comb begin
        evt           = '0;
        evt.startStop = btnRise[0];
        evt.lap       = btnRise[1] & ~btnRise[0];
        evt.clear     = btnRise[2] & ~btnRise[1] & ~btnRise[0];
    end

    // ---------------- FSM ----------------
    swState_e state, stateNext;
    logic     takeSnap, clrCount;

    always_comb begin
        stateNext = state;
        takeSnap  = 1'b0;
        clrCount  = 1'b0;
        case (state)
            IDLE:   if (evt.startStop) stateNext = RUN;
            RUN:    if (evt.startStop) stateNext = PAUSED;
                    else if (evt.lap) begin
                        stateNext = LAP;
                        takeSnap  = 1'b1;
                    end
            LAP:    if (evt.startStop) stateNext = PAUSED;
                    else if (evt.lap) stateNext = RUN;
            PAUSED: if (evt.startStop) stateNext = RUN;
                    else if (evt.clear) begin
                        stateNext = IDLE;
                        clrCount  = 1'b1;
                    end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    assign running    = (state == RUN) || (state == LAP);
    assign lap_active = (state == LAP);

    // ---------------- prescaler ----------------
    // Holds in PAUSED so a resume keeps the sub-tick phase.
    logic [PW-1:0] pre;
    logic          tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pre <= '0;
        else if (state == IDLE || clrCount)
            pre <= '0;
        else if (running)
            pre <= (pre == PRE_MAX) ? '0 : pre + PW'(1);
    end

    assign tick = (pre == PRE_MAX) && running;

    // ---------------- BCD cascade ----------------
    logic [NUM_DIGITS:0]                    chainEn;
    logic [NUM_DIGITS-1:0]                  digCarry;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     liveCount, snapshot, dispSrc;

    // chainEn[i] = tick and every lower digit at max; the top bit is the wrap
    always_comb begin
        chainEn    = '0;
        chainEn[0] = tick;
        for (int i = 0; i < NUM_DIGITS; i++)
            chainEn[i+1] = chainEn[i] & digCarry[i];
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDigit
        bcd_digit_counter uDigit (
            .clk   (clk),
            .reset (reset),
            .clr   (clrCount),
            .en    (chainEn[i]),
            .max   (DIG_MAX[i]),
            .q     (liveCount[i]),
            .carry (digCarry[i])
        );
    end

    assign count_bcd = liveCount;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_ovf  <= 1'b0;
            snapshot <= '0;
        end else begin
            min_ovf <= chainEn[NUM_DIGITS];
            if (takeSnap) snapshot <= liveCount;
        end
    end

    // ---------------- display scan ----------------
    logic [SW-1:0] scanCnt;
    logic [1:0]    scanIdx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scanCnt <= '0;
            scanIdx <= '0;
        end else if (scanCnt == SCAN_MAX) begin
            scanCnt <= '0;
            scanIdx <= scanIdx + 2'd1;
        end else begin
            scanCnt <= scanCnt + SW'(1);
        end
    end

    assign dispSrc   = lap_active ? snapshot : liveCount;
    assign digit_bcd = dispSrc[scanIdx];
    assign digit_sel = ~(4'b0001 << scanIdx);
    assign dp        = DP_MASK[scanIdx];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btnSs = 1'b0, btnLap = 1'b0, btnClr = 1'b0;
    logic [15:0] countBcd;
    logic [3:0]  digitBcd, digitSel;
    logic        dpOut, runningOut, lapOut, ovfOut;

    int passCnt = 0;
    int totalCnt = 0;
    int cyc = 0;

    logic [15:0] cntQ[$];
    logic [8:0]  scanQ[$];   // {sel, bcd, dp}

    stopwatch_ctrl #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_stop (btnSs),
        .btn_lap        (btnLap),
        .btn_clear      (btnClr),
        .count_bcd      (countBcd),
        .digit_bcd      (digitBcd),
        .digit_sel      (digitSel),
        .dp             (dpOut),
        .running        (runningOut),
        .lap_active     (lapOut),
        .min_ovf        (ovfOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: sim time limit reached, passed %0d of %0d", passCnt, totalCnt);
        $fatal(1);
    end

    function automatic logic [15:0] toBcd(input int n);
        int t, s;
        t = n % 6000;
        s = (t / 10) % 60;
        return {4'(t / 600), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
    endfunction

    task automatic waitUntil(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // called at a negedge; button high for one posedge, state moves 2 edges after return
    task automatic press(input logic ss, input logic lp, input logic cl);
        btnSs = ss; btnLap = lp; btnClr = cl;
        @(negedge clk);
        btnSs = 1'b0; btnLap = 1'b0; btnClr = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] s;
        logic [8:0] e;
        int i, w;
        logic [3:0] prevSel;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        totalCnt++;
        if ({countBcd, digitBcd, digitSel, dpOut, runningOut, lapOut, ovfOut} !== {16'h0, 4'h0, 4'b1110, 4'b0000}) begin
            $display("FAIL reset_vals: got cnt=%h bcd=%h sel=%b dp=%b run=%b lap=%b ovf=%b, want 0000 0 1110 0 0 0 0",
                     countBcd, digitBcd, digitSel, dpOut, runningOut, lapOut, ovfOut);
        end else passCnt++;
        for (int k = 0; k < 8; k++) begin
            i = (k + 1) % 4;
            s = 4'b0001 << i;
            scanQ.push_back({~s, 4'h0, (i == 1 || i == 3)});
        end
        while (scanQ.size() > 0) begin
            prevSel = digitSel;
            w = 0;
            while (digitSel === prevSel && w < 6) begin @(negedge clk); w++; end
            e = scanQ.pop_front();
            totalCnt++;
            if (w !== 2) $display("FAIL scan_period: got %0d clks want 2", w);
            else passCnt++;
            totalCnt++;
            if ({digitSel, digitBcd, dpOut} !== e) $display("FAIL scan_idle: got %b want %b", {digitSel, digitBcd, dpOut}, e);
            else passCnt++;
        end
        repeat (4) @(negedge clk);
        totalCnt++;
        if ({countBcd, runningOut, lapOut, ovfOut} !== {16'h0, 3'b000}) $display("FAIL idle_hold: got cnt=%h run=%b lap=%b ovf=%b want 0000 0 0 0", countBcd, runningOut, lapOut, ovfOut);
        else passCnt++;
    endtask

    task automatic test_run_pause;
        int base, w;
        logic [15:0] last, e;
        press(1, 0, 0);
        base = cyc;
        waitUntil(base + 2);
        totalCnt++;
        if (runningOut !== 1'b1) $display("FAIL run_state: running=%b want 1", runningOut);
        else passCnt++;
        for (int n = 1; n <= 10; n++) cntQ.push_back(toBcd(n));
        while (cntQ.size() > 0) begin
            last = countBcd;
            w = 0;
            while (countBcd === last && w < 8) begin @(negedge clk); w++; end
            e = cntQ.pop_front();
            totalCnt++;
            if (countBcd !== e) $display("FAIL run_count: got %h want %h", countBcd, e);
            else passCnt++;
        end
        totalCnt++;
        if (cyc !== base + 42) $display("FAIL run_timing: 1.0 s reached at cycle %0d want %0d", cyc - base, 42);
        else passCnt++;
        press(1, 0, 0);
        waitUntil(base + 45);
        totalCnt++;
        if (runningOut !== 1'b0) $display("FAIL pause_state: running=%b want 0", runningOut);
        else passCnt++;
        repeat (20) @(negedge clk);
        totalCnt++;
        if ({countBcd, runningOut} !== {16'h0010, 1'b0}) $display("FAIL pause_hold: got cnt=%h run=%b want 0010 0", countBcd, runningOut);
        else passCnt++;
    endtask

    task automatic test_rollover;
        int base;
        press(0, 0, 1);
        waitUntil(cyc + 3);
        totalCnt++;
        if ({countBcd, runningOut} !== {16'h0, 1'b0}) $display("FAIL clear_paused: got cnt=%h run=%b want 0000 0", countBcd, runningOut);
        else passCnt++;
        press(1, 0, 0);
        base = cyc;
        waitUntil(base + 2 + 4 * 5999);
        totalCnt++;
        if ({countBcd, ovfOut} !== {16'h9599, 1'b0}) $display("FAIL cnt_9599: got cnt=%h ovf=%b want 9599 0", countBcd, ovfOut);
        else passCnt++;
        waitUntil(base + 24001);
        totalCnt++;
        if ({countBcd, ovfOut} !== {16'h9599, 1'b0}) $display("FAIL pre_wrap: got cnt=%h ovf=%b want 9599 0", countBcd, ovfOut);
        else passCnt++;
        waitUntil(base + 24002);
        totalCnt++;
        if ({countBcd, ovfOut} !== {16'h0000, 1'b1}) $display("FAIL wrap: got cnt=%h ovf=%b want 0000 1", countBcd, ovfOut);
        else passCnt++;
        waitUntil(base + 24003);
        totalCnt++;
        if ({countBcd, ovfOut} !== {16'h0000, 1'b0}) $display("FAIL ovf_pulse: got cnt=%h ovf=%b want 0000 0", countBcd, ovfOut);
        else passCnt++;
    endtask

    task automatic test_lap;
        int base, w;
        logic [3:0] prevSel;
        logic [8:0] e;
        logic found;
        press(1, 0, 0);
        waitUntil(cyc + 3);
        press(0, 0, 1);
        waitUntil(cyc + 3);
        press(1, 0, 0);
        base = cyc;
        waitUntil(base + 94);
        press(0, 1, 0);
        waitUntil(base + 98);
        totalCnt++;
        if ({lapOut, runningOut} !== 2'b11) $display("FAIL lap_state: lap=%b run=%b want 1 1", lapOut, runningOut);
        else passCnt++;
        // frozen display 0:02.3, from the tenths slot upward
        for (int k = 0; k < 16 && digitSel !== 4'b1110; k++) @(negedge clk);
        found = (digitSel === 4'b1110);
        scanQ.push_back({4'b1110, 4'd3, 1'b0});
        scanQ.push_back({4'b1101, 4'd2, 1'b1});
        scanQ.push_back({4'b1011, 4'd0, 1'b0});
        scanQ.push_back({4'b0111, 4'd0, 1'b1});
        totalCnt++;
        if (!found) $display("FAIL lap_align: digit_sel=%b never reached 1110", digitSel);
        else passCnt++;
        while (scanQ.size() > 0) begin
            e = scanQ.pop_front();
            totalCnt++;
            if ({digitSel, digitBcd, dpOut} !== e) $display("FAIL lap_scan: got %b want %b", {digitSel, digitBcd, dpOut}, e);
            else passCnt++;
            prevSel = digitSel;
            w = 0;
            while (scanQ.size() > 0 && digitSel === prevSel && w < 4) begin @(negedge clk); w++; end
        end
        waitUntil(base + 121);
        press(0, 1, 0);
        totalCnt++;
        if ({countBcd, lapOut} !== {16'h0030, 1'b1}) $display("FAIL lap_live: got cnt=%h lap=%b want 0030 1", countBcd, lapOut);
        else passCnt++;
        press(1, 0, 0);
        waitUntil(base + 126);
        totalCnt++;
        if ({countBcd, runningOut, lapOut} !== {16'h0030, 2'b00}) $display("FAIL lap_exit: got cnt=%h run=%b lap=%b want 0030 0 0", countBcd, runningOut, lapOut);
        else passCnt++;
        for (int k = 0; k < 16 && digitSel !== 4'b1110; k++) @(negedge clk);
        scanQ.push_back({4'b1110, 4'd0, 1'b0});
        scanQ.push_back({4'b1101, 4'd3, 1'b1});
        scanQ.push_back({4'b1011, 4'd0, 1'b0});
        scanQ.push_back({4'b0111, 4'd0, 1'b1});
        while (scanQ.size() > 0) begin
            e = scanQ.pop_front();
            totalCnt++;
            if ({digitSel, digitBcd, dpOut} !== e) $display("FAIL live_scan: got %b want %b", {digitSel, digitBcd, dpOut}, e);
            else passCnt++;
            prevSel = digitSel;
            w = 0;
            while (scanQ.size() > 0 && digitSel === prevSel && w < 4) begin @(negedge clk); w++; end
        end
    endtask

    task automatic test_priority;
        int b;
        press(1, 0, 0);
        b = cyc;
        waitUntil(b + 2);
        totalCnt++;
        if ({countBcd, runningOut} !== {16'h0030, 1'b1}) $display("FAIL resume: got cnt=%h run=%b want 0030 1", countBcd, runningOut);
        else passCnt++;
        waitUntil(b + 3);
        totalCnt++;
        if (countBcd !== 16'h0031) $display("FAIL phase_hold: got cnt=%h want 0031", countBcd);
        else passCnt++;
        press(0, 0, 1);
        waitUntil(b + 7);
        totalCnt++;
        if ({countBcd, runningOut, lapOut} !== {16'h0032, 2'b10}) $display("FAIL clear_in_run: got cnt=%h run=%b lap=%b want 0032 1 0", countBcd, runningOut, lapOut);
        else passCnt++;
        press(1, 1, 0);
        waitUntil(b + 12);
        totalCnt++;
        if ({countBcd, runningOut, lapOut} !== {16'h0032, 2'b00}) $display("FAIL ss_over_lap: got cnt=%h run=%b lap=%b want 0032 0 0", countBcd, runningOut, lapOut);
        else passCnt++;
        press(0, 0, 1);
        waitUntil(b + 14);
        totalCnt++;
        if (countBcd !== 16'h0032) $display("FAIL clear_latency: got cnt=%h want 0032", countBcd);
        else passCnt++;
        waitUntil(b + 15);
        totalCnt++;
        if ({countBcd, runningOut, lapOut} !== {16'h0000, 2'b00}) $display("FAIL clear_idle: got cnt=%h run=%b lap=%b want 0000 0 0", countBcd, runningOut, lapOut);
        else passCnt++;
    endtask

    task automatic test_async_reset;
        int base;
        press(1, 0, 0);
        base = cyc;
        waitUntil(base + 19);
        totalCnt++;
        if ({countBcd, runningOut} !== {16'h0004, 1'b1}) $display("FAIL pre_reset: got cnt=%h run=%b want 0004 1", countBcd, runningOut);
        else passCnt++;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        totalCnt++;
        if ({countBcd, digitBcd, digitSel, dpOut, runningOut, lapOut, ovfOut} !== {16'h0, 4'h0, 4'b1110, 4'b0000})
            $display("FAIL async_reset: got cnt=%h bcd=%h sel=%b dp=%b run=%b lap=%b ovf=%b, want 0000 0 1110 0 0 0 0",
                     countBcd, digitBcd, digitSel, dpOut, runningOut, lapOut, ovfOut);
        else passCnt++;
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        totalCnt++;
        if ({countBcd, runningOut, lapOut} !== {16'h0, 2'b00}) $display("FAIL post_reset_idle: got cnt=%h run=%b lap=%b want 0000 0 0", countBcd, runningOut, lapOut);
        else passCnt++;
    endtask

    initial begin
        test_reset();
        test_run_pause();
        test_rollover();
        test_lap();
        test_priority();
        test_async_reset();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
